// File: rtl/cook_pkg.sv
// Shared state encoding and constants for the microwave cook sequencer.
package cook_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cook_state_t;

  localparam int SLOT_W          = 3;
  localparam int SLOTS           = 8;
  localparam int ALARM_BEATS_DEF = 3;
  localparam int ADD_SECS_DEF    = 30;

endpackage

// File: rtl/cook_sequencer_duty_slot.sv
// Magnetron duty window: beat-driven slot counter and the slot-vs-power compare.
module duty_slot
  import cook_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              clr,
  input  logic [SLOT_W-1:0] power,
  output logic              duty_on
);

  logic [SLOT_W-1:0] slot_r;

  // Slot counter: clear wins over advance; wraps after the last slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_r <= '0;
    end else if (clr) begin
      slot_r <= '0;
    end else if (adv) begin
      if (slot_r == SLOT_W'(SLOTS - 1)) begin
        slot_r <= '0;
      end else begin
        slot_r <= slot_r + SLOT_W'(1);
      end
    end else begin
      slot_r <= slot_r;
    end
  end

  assign duty_on = (slot_r <= power);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook-cycle sequencer: countdown, magnetron duty cycling, door interlock, alarm.
// Optional macro ADD30_EN: start while cooking adds ADD_SECS to the remaining time.
module cook_sequencer
  import cook_pkg::*;
#(
  parameter int TIME_W      = 16,
  parameter int ALARM_BEATS = ALARM_BEATS_DEF,
  parameter int ADD_SECS    = ADD_SECS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic              start,
  input  logic              stop,
  input  logic              door_open,
  input  logic [TIME_W-1:0] time_in,
  input  logic [2:0]        power_in,
  output logic              magnetron_on,
  output logic              lamp_on,
  output logic [TIME_W-1:0] remaining,
  output logic [1:0]        state_code,
  output logic              done_pulse,
  output logic              alarm
);

  localparam int CNT_W = $clog2(ALARM_BEATS + 1);

  cook_state_t       state_r;
  cook_state_t       state_nxt_s;
  logic [TIME_W-1:0] remaining_r;
  logic [TIME_W-1:0] remaining_nxt_s;
  logic [SLOT_W-1:0] power_r;
  logic [SLOT_W-1:0] power_nxt_s;
  logic [CNT_W-1:0]  alarm_cnt_r;
  logic [CNT_W-1:0]  alarm_cnt_nxt_s;
  logic              done_pulse_r;
  logic              alarm_r;
  logic              add_s;
  logic              slot_adv_s;
  logic              slot_clr_s;
  logic              duty_on_s;
  logic [TIME_W:0]   sum_s;

`ifdef ADD30_EN
  assign add_s = start;
`else
  assign add_s = 1'b0;
`endif

  // One extra bit catches overflow for saturation; a same-cycle beat is folded in.
  assign sum_s = {1'b0, remaining_r} + (TIME_W+1)'(ADD_SECS) - {{TIME_W{1'b0}}, beat};

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !stop && !door_open && (time_in != '0)) begin
          state_nxt_s = COOK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COOK: begin
        if (door_open || stop) begin
          state_nxt_s = PAUSE;
        end else if (beat && !add_s && (remaining_r == TIME_W'(1))) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = COOK;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt_s = IDLE;
        end else if (start && !door_open) begin
          state_nxt_s = COOK;
        end else begin
          state_nxt_s = PAUSE;
        end
      end
      DONE: begin
        if (stop || door_open) begin
          state_nxt_s = IDLE;
        end else if (beat && (alarm_cnt_r == CNT_W'(ALARM_BEATS - 1))) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath control: countdown, power sampling, slot control, alarm count
  always_comb begin
    remaining_nxt_s = remaining_r;
    power_nxt_s     = power_r;
    alarm_cnt_nxt_s = '0;
    slot_adv_s      = 1'b0;
    slot_clr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (state_nxt_s == COOK) begin
          remaining_nxt_s = time_in;
          power_nxt_s     = power_in;
          slot_clr_s      = 1'b1;
        end else begin
          remaining_nxt_s = '0;
        end
      end
      COOK: begin
        if (door_open || stop) begin
          remaining_nxt_s = remaining_r;
        end else if (add_s) begin
          slot_adv_s = beat;
          if (sum_s[TIME_W]) begin
            remaining_nxt_s = '1;
          end else begin
            remaining_nxt_s = sum_s[TIME_W-1:0];
          end
        end else if (beat) begin
          slot_adv_s      = 1'b1;
          remaining_nxt_s = remaining_r - TIME_W'(1);
        end else begin
          remaining_nxt_s = remaining_r;
        end
      end
      PAUSE: begin
        if (stop) begin
          remaining_nxt_s = '0;
          slot_clr_s      = 1'b1;
        end else begin
          remaining_nxt_s = remaining_r;
        end
      end
      DONE: begin
        if ((state_nxt_s == DONE) && beat) begin
          alarm_cnt_nxt_s = alarm_cnt_r + CNT_W'(1);
        end else if (state_nxt_s == DONE) begin
          alarm_cnt_nxt_s = alarm_cnt_r;
        end else begin
          alarm_cnt_nxt_s = '0;
        end
        slot_clr_s = (state_nxt_s == IDLE);
      end
      default: begin
        remaining_nxt_s = '0;
        slot_clr_s      = 1'b1;
      end
    endcase
  end

  // Countdown, sampled power, alarm counter and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_r  <= '0;
      power_r      <= '0;
      alarm_cnt_r  <= '0;
      done_pulse_r <= 1'b0;
      alarm_r      <= 1'b0;
    end else begin
      remaining_r  <= remaining_nxt_s;
      power_r      <= power_nxt_s;
      alarm_cnt_r  <= alarm_cnt_nxt_s;
      done_pulse_r <= (state_r == COOK) && (state_nxt_s == DONE);
      alarm_r      <= (state_nxt_s == DONE);
    end
  end

  duty_slot u_duty_slot (
    .clk     (clk),
    .reset   (reset),
    .adv     (slot_adv_s),
    .clr     (slot_clr_s),
    .power   (power_r),
    .duty_on (duty_on_s)
  );

  // Interlock outputs stay combinational so an opening door cuts the magnetron immediately.
  assign magnetron_on = (state_r == COOK) && duty_on_s && !door_open;
  assign lamp_on      = door_open || (state_r == COOK);
  assign remaining    = remaining_r;
  assign state_code   = state_r;
  assign done_pulse   = done_pulse_r;
  assign alarm        = alarm_r;

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer: directed scenarios plus randomized run against a reference model.
`timescale 1ns/1ps
module tb_cook_sequencer;

  localparam int TW   = 16;
  localparam int TMAX = 65535;
  localparam int ADD  = 30;
  localparam int AB   = 3;
`ifdef ADD30_EN
  localparam bit ADD30 = 1'b1;
`else
  localparam bit ADD30 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          beat = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          door_open = 1'b0;
  logic [TW-1:0] time_in = '0;
  logic [2:0]    power_in = '0;
  logic          magnetron_on;
  logic          lamp_on;
  logic [TW-1:0] remaining;
  logic [1:0]    state_code;
  logic          done_pulse;
  logic          alarm;
  logic [21:0]   obs;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state (state numbering as on state_code)
  int m_state, m_rem, m_pwr, m_slot, m_acnt;
  bit m_done;

  cook_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .beat         (beat),
    .start        (start),
    .stop         (stop),
    .door_open    (door_open),
    .time_in      (time_in),
    .power_in     (power_in),
    .magnetron_on (magnetron_on),
    .lamp_on      (lamp_on),
    .remaining    (remaining),
    .state_code   (state_code),
    .done_pulse   (done_pulse),
    .alarm        (alarm)
  );

  assign obs = {state_code, remaining, magnetron_on, lamp_on, done_pulse, alarm};

  always #5 clk = ~clk;

  task automatic step(input logic b, input logic st, input logic sp);
    beat = b; start = st; stop = sp;
    @(posedge clk);
    #1;
    beat = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; beat = 1'b0; start = 1'b0; stop = 1'b0; door_open = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic void model_step(input bit b, input bit st, input bit sp, input bit dr,
                                     input int t, input int p);
    m_done = 1'b0;
    case (m_state)
      0: begin
        if (st && !sp && !dr && t != 0) begin
          m_state = 1; m_rem = t; m_pwr = p; m_slot = 0;
        end
      end
      1: begin
        if (dr || sp) begin
          m_state = 2;
        end else if (ADD30 && st) begin
          m_rem = m_rem - int'(b) + ADD;
          if (m_rem > TMAX) m_rem = TMAX;
          if (b) m_slot = (m_slot + 1) % 8;
        end else if (b) begin
          m_slot = (m_slot + 1) % 8;
          m_rem  = m_rem - 1;
          if (m_rem == 0) begin
            m_state = 3; m_acnt = 0; m_done = 1'b1;
          end
        end
      end
      2: begin
        if (sp) begin
          m_state = 0; m_rem = 0;
        end else if (st && !dr) begin
          m_state = 1;
        end
      end
      default: begin
        if (sp || dr) begin
          m_state = 0;
        end else if (b) begin
          m_acnt = m_acnt + 1;
          if (m_acnt == AB) m_state = 0;
        end
      end
    endcase
  endfunction

  task automatic test_reset();
    logic [21:0] exp_v;
    reset = 1'b0; door_open = 1'b0;
    #1;
    exp_v = {2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
    door_open = 1'b1;
    #1;
    exp_v = {2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_lamp: got %h want %h", obs, exp_v); end
    door_open = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_power();
    logic [21:0] exp_v;
    do_reset();
    time_in = 16'd3; power_in = 3'd7;
    step(1'b0, 1'b1, 1'b0);
    exp_v = {2'd1, 16'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL full_start: got %h want %h", obs, exp_v); end
    for (int i = 2; i >= 1; i--) begin
      step(1'b1, 1'b0, 1'b0);
      exp_v = {2'd1, 16'(i), 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL full_count%0d: got %h want %h", i, obs, exp_v); end
    end
    step(1'b1, 1'b0, 1'b0);
    exp_v = {2'd3, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL full_done: got %h want %h", obs, exp_v); end
    step(1'b0, 1'b1, 1'b0);
    exp_v = {2'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL full_alarm_hold: got %h want %h", obs, exp_v); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL full_alarm_beat2: got %h want %h", obs, exp_v); end
    step(1'b1, 1'b0, 1'b0);
    exp_v = {2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL full_back_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_low_power();
    int highs;
    highs = 0;
    do_reset();
    time_in = 16'd16; power_in = 3'd1;
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (magnetron_on !== (k <= 1)) begin
        n_fail++; $display("FAIL duty_slot%0d: got %b want %b", k, magnetron_on, (k <= 1));
      end
      if (magnetron_on === 1'b1) highs++;
      step(1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if (highs !== 2) begin n_fail++; $display("FAIL duty_count: got %0d want 2", highs); end
    n_cmp++;
    if ({magnetron_on, remaining} !== {1'b1, 16'd8}) begin
      n_fail++; $display("FAIL duty_wrap: got %b/%0d want 1/8", magnetron_on, remaining);
    end
  endtask

  task automatic test_door_pause();
    logic [21:0] exp_v;
    do_reset();
    time_in = 16'd5; power_in = 3'd7;
    step(1'b0, 1'b1, 1'b0);
    exp_v = {2'd1, 16'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL door_precook: got %h want %h", obs, exp_v); end
    door_open = 1'b1; beat = 1'b1;
    #1;
    n_cmp++; if (magnetron_on !== 1'b0) begin n_fail++; $display("FAIL door_kill: got %b want 0", magnetron_on); end
    @(posedge clk);
    #1 beat = 1'b0;
    @(negedge clk);
    exp_v = {2'd2, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL door_pause: got %h want %h", obs, exp_v); end
    door_open = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    exp_v = {2'd2, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL pause_beat: got %h want %h", obs, exp_v); end
    step(1'b0, 1'b1, 1'b0);
    exp_v = {2'd1, 16'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL door_resume: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_pause_cancel();
    logic [21:0] exp_v;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    exp_v = {2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL cancel_idle: got %h want %h", obs, exp_v); end
    time_in = 16'd0;
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL zero_time: got %h want %h", obs, exp_v); end
    time_in = 16'd5; door_open = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    exp_v = {2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL door_start: got %h want %h", obs, exp_v); end
    door_open = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    exp_v = {2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL start_stop: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_done_stop_reset();
    logic [21:0] exp_v;
    do_reset();
    time_in = 16'd1; power_in = 3'd0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp_v = {2'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL done_cnt1: got %h want %h", obs, exp_v); end
    step(1'b0, 1'b0, 1'b1);
    exp_v = {2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL done_stop: got %h want %h", obs, exp_v); end
    time_in = 16'd9; power_in = 3'd3;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp_v = {2'd1, 16'd8, 1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL precut: got %h want %h", obs, exp_v); end
    #2 reset = 1'b0;
    #1;
    exp_v = {2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp_v); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL post_reset: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_add30();
    logic [21:0] exp_v;
    do_reset();
    time_in = 16'd10; power_in = 3'd7;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
`ifdef ADD30_EN
    exp_v = {2'd1, 16'd40, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_v = {2'd1, 16'd10, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL add_plain: got %h want %h", obs, exp_v); end
    step(1'b1, 1'b1, 1'b0);
`ifdef ADD30_EN
    exp_v = {2'd1, 16'd69, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_v = {2'd1, 16'd9, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL add_beat: got %h want %h", obs, exp_v); end
    do_reset();
    time_in = 16'd65530;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
`ifdef ADD30_EN
    exp_v = {2'd1, 16'd65535, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_v = {2'd1, 16'd65530, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL add_sat: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_random();
    logic        b, st, sp, mag_e;
    logic [21:0] exp_v;
    do_reset();
    m_state = 0; m_rem = 0; m_pwr = 0; m_slot = 0; m_acnt = 0; m_done = 1'b0;
    for (int i = 0; i < 800; i++) begin
      b  = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 4) == 0);
      sp = ($urandom_range(0, 19) == 0);
      door_open = door_open ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0);
      time_in  = TW'($urandom_range(0, 12));
      power_in = 3'($urandom_range(0, 7));
      beat = b; start = st; stop = sp;
      @(posedge clk);
      model_step(b, st, sp, door_open, int'(time_in), int'(power_in));
      #1;
      beat = 1'b0; start = 1'b0; stop = 1'b0;
      @(negedge clk);
      mag_e = (m_state == 1) && (m_slot <= m_pwr) && !door_open;
      exp_v = {2'(m_state), 16'(m_rem), mag_e, door_open || (m_state == 1), m_done, (m_state == 3)};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL rand_cycle%0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_power();
    test_low_power();
    test_door_pause();
    test_pause_cancel();
    test_done_stop_reset();
    test_add30();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
